// File: rtl/mcycle_pkg.sv
// Shared definitions for the multi-cycle multiply/divide unit.
//   MCYCLE_WIDTH  : default operand/result width
//   mcycle_op_e   : MCycleOp encodings (signed/unsigned mul/div)
//   mcycle_state_e: controller state encoding
package mcycle_pkg;

   localparam int unsigned MCYCLE_WIDTH = 32;

   typedef enum logic [1:0] {
      OP_SMUL = 2'b00,
      OP_UMUL = 2'b01,
      OP_SDIV = 2'b10,
      OP_UDIV = 2'b11
   } mcycle_op_e;

   typedef enum logic {
      S_IDLE      = 1'b0,
      S_COMPUTING = 1'b1
   } mcycle_state_e;

   function automatic logic op_is_div(input logic [1:0] op);
      return (op == OP_SDIV) || (op == OP_UDIV);
   endfunction

   function automatic logic op_is_signed(input logic [1:0] op);
      return (op == OP_SMUL) || (op == OP_SDIV);
   endfunction

endpackage

// File: rtl/mcycle.sv
// Multi-cycle multiply/divide unit. One shift-and-add (mul) or restoring
// subtract-shift (div) iteration per clock, WIDTH iterations per operation.
// Ports:
//   CLK, RESETn         : clock, asynchronous active-low reset
//   Start, MCycleOp     : request and operation, sampled only in IDLE
//   Operand1, Operand2  : multiplicand/dividend, multiplier/divisor
//   Result1, Result2    : mul low/high product, div quotient/remainder (registered)
//   Busy                : operation accepted or in progress (stall request)
//   Done                : one-cycle pulse when Result1/Result2 are updated
module mcycle
   import mcycle_pkg::*;
#(
   parameter int unsigned WIDTH = MCYCLE_WIDTH
)
(
   input  logic             CLK,
   input  logic             RESETn,
   input  logic             Start,
   input  logic [1:0]       MCycleOp,
   input  logic [WIDTH-1:0] Operand1,
   input  logic [WIDTH-1:0] Operand2,
   output logic [WIDTH-1:0] Result1,
   output logic [WIDTH-1:0] Result2,
   output logic             Busy,
   output logic             Done
);

   localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   mcycle_state_e        state_q;
   logic [CNT_W-1:0]     count_q;
   logic                 is_div_q;
   logic                 neg_q;      // product/quotient must be negated
   logic                 rneg_q;     // remainder must be negated (dividend sign)
   logic                 div0_q;     // divide by zero: quotient stays all ones
   logic [WIDTH-1:0]     mag_q;      // multiplicand or divisor magnitude
   logic [2*WIDTH-1:0]   shift_q;
   logic [2*WIDTH-1:0]   shift_d;
   logic [WIDTH-1:0]     res1_q;
   logic [WIDTH-1:0]     res2_q;
   logic                 done_q;

   // Operand conditioning at acceptance time
   logic                 sgn1, sgn2;
   logic [WIDTH-1:0]     mag1, mag2;

   // Shared adder/subtractor
   logic [WIDTH:0]       add_a, add_b, sum;
   logic                 div_ok;

   // Output conditioning on the last iteration
   logic [2*WIDTH-1:0]   prod;
   logic [WIDTH-1:0]     quot, rem;
   logic [WIDTH-1:0]     fin1, fin2;

   always_comb begin
      sgn1 = op_is_signed(MCycleOp) & Operand1[WIDTH-1];
      sgn2 = op_is_signed(MCycleOp) & Operand2[WIDTH-1];
      // -(-2^(WIDTH-1)) wraps to 2^(WIDTH-1), which is the correct unsigned magnitude
      mag1 = sgn1 ? -Operand1 : Operand1;
      mag2 = sgn2 ? -Operand2 : Operand2;
   end

   always_comb begin
      add_a  = '0;
      add_b  = '0;
      sum    = '0;
      div_ok = 1'b0;
      shift_d = shift_q;
      if (is_div_q) begin
         // Shifted partial remainder minus divisor; bit WIDTH set means borrow
         add_a = shift_q[2*WIDTH-1:WIDTH-1];
         add_b = {1'b0, mag_q};
      end else begin
         // Add multiplicand into the high half when the current multiplier bit is set
         add_a = {1'b0, shift_q[2*WIDTH-1:WIDTH]};
         add_b = shift_q[0] ? {1'b0, mag_q} : '0;
      end
      sum = add_a + (add_b ^ {(WIDTH+1){is_div_q}}) + {{WIDTH{1'b0}}, is_div_q};
      if (is_div_q) begin
         div_ok  = ~sum[WIDTH];
         shift_d = {(div_ok ? sum[WIDTH-1:0] : shift_q[2*WIDTH-2:WIDTH-1]),
                    shift_q[WIDTH-2:0], div_ok};
      end else begin
         shift_d = {sum, shift_q[WIDTH-1:1]};
      end
   end

   always_comb begin
      prod = neg_q ? -shift_d : shift_d;
      quot = shift_d[WIDTH-1:0];
      rem  = shift_d[2*WIDTH-1:WIDTH];
      if (is_div_q) begin
         fin1 = (neg_q && !div0_q) ? -quot : quot;
         fin2 = rneg_q ? -rem : rem;
      end else begin
         fin1 = prod[WIDTH-1:0];
         fin2 = prod[2*WIDTH-1:WIDTH];
      end
   end

   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         state_q  <= S_IDLE;
         count_q  <= '0;
         is_div_q <= 1'b0;
         neg_q    <= 1'b0;
         rneg_q   <= 1'b0;
         div0_q   <= 1'b0;
         mag_q    <= '0;
         shift_q  <= '0;
         res1_q   <= '0;
         res2_q   <= '0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (Start) begin
                  is_div_q <= op_is_div(MCycleOp);
                  neg_q    <= sgn1 ^ sgn2;
                  rneg_q   <= sgn1;
                  div0_q   <= op_is_div(MCycleOp) && (Operand2 == '0);
                  // mul: shift register holds the multiplier, mag_q the multiplicand
                  // div: shift register holds the dividend, mag_q the divisor
                  mag_q    <= op_is_div(MCycleOp) ? mag2 : mag1;
                  shift_q  <= {{WIDTH{1'b0}}, (op_is_div(MCycleOp) ? mag1 : mag2)};
                  count_q  <= '0;
                  state_q  <= S_COMPUTING;
               end
            end
            S_COMPUTING: begin
               shift_q <= shift_d;
               count_q <= count_q + CNT_ONE;
               if (count_q == LAST_CNT) begin
                  res1_q  <= fin1;
                  res2_q  <= fin2;
                  done_q  <= 1'b1;
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign Busy    = ((state_q == S_IDLE) && Start) || (state_q == S_COMPUTING);
   assign Done    = done_q;
   assign Result1 = res1_q;
   assign Result2 = res2_q;

endmodule

// File: doc/mcycle.md
MCYCLE -- requirements
Module: mcycle

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width.
REQ-002 CLK  input  1  sole clock, all state updates on rising edge.
REQ-003 RESETn  input  1  reset, asynchronous, active-low.
REQ-004 Start  input  1  request new operation, sampled only in IDLE.
REQ-005 MCycleOp  input  2  operation: 00 signed mul, 01 unsigned mul, 10 signed div, 11 unsigned div.
REQ-006 Operand1  input  WIDTH  multiplicand / dividend, driven from register-file RD1.
REQ-007 Operand2  input  WIDTH  multiplier / divisor, driven from register-file RD2.
REQ-008 Result1  output  WIDTH  mul: product low half; div: quotient; registered.
REQ-009 Result2  output  WIDTH  mul: product high half; div: remainder; registered.
REQ-010 Busy  output  1  operation accepted or in progress; pipeline stall request.
REQ-011 Done  output  1  one-cycle pulse, Result1/Result2 valid and updated.

Function
REQ-012 States IDLE and COMPUTING only; IDLE after reset.
REQ-013 IDLE with Start=1 at edge k: latch MCycleOp, operand magnitudes and sign flags, count=0, go to COMPUTING.
REQ-014 Busy = (IDLE and Start) or COMPUTING, combinational, so Busy is high in the cycle Start first appears.
REQ-015 COMPUTING performs one iteration per edge: mul shift-and-add of one multiplier bit; div one restoring subtract-shift step producing one quotient bit.
REQ-016 Edge k+WIDTH performs last iteration, loads Result1/Result2, sets Done=1 for one cycle, returns to IDLE; Busy=0 in that cycle.
REQ-017 Latency: results valid WIDTH cycles after the Start-sampling edge; throughput one op per WIDTH+1 cycles minimum.
REQ-018 Start, MCycleOp and operands ignored while COMPUTING; operands need only be stable at edge k.
REQ-019 Start still high in the IDLE cycle following Done starts a new operation; controller drops Start when Busy falls.
REQ-020 Result1/Result2 hold last values between operations and during COMPUTING.
REQ-021 Unsigned mul: {Result2,Result1} = Operand1 × Operand2, full 2×WIDTH product.
REQ-022 Signed mul: magnitudes multiplied, 2×WIDTH product negated when operand signs differ.
REQ-023 Unsigned div: Result1 = floor(Op1/Op2), Result2 = Op1 mod Op2.
REQ-024 Signed div: quotient truncates toward zero; remainder takes sign of Operand1; quotient negated when signs differ.
REQ-025 Divide by zero (any div op): Result1 = all ones, Result2 = Operand1, still WIDTH cycles, no error flag.
REQ-026 Signed overflow (-2^(WIDTH-1) / -1): Result1 = 0x80000000 (WIDTH=32), Result2 = 0.
REQ-027 Magnitude of -2^(WIDTH-1) handled as unsigned 2^(WIDTH-1), no internal overflow.

Reset
REQ-028 RESETn low forces, without clock, state=IDLE, count=0, Result1=0, Result2=0, Done=0; Busy then follows Start only.
REQ-029 RESETn low mid-operation aborts it; no Done, results cleared; first Start after release begins fresh.

Structure
REQ-030 Shared package mcycle_pkg holds MCycleOp encodings, state encoding and default WIDTH.
REQ-031 Single module, no sub-module: one shared WIDTH+1-bit adder/subtractor, 2×WIDTH shift register, log2(WIDTH)+1-bit counter.
REQ-032 Sign conditioning (abs in, negate out) inside mcycle, registered, not on the Start path.

Verification
REQ-033 Op=01, 0xFFFFFFFF × 0xFFFFFFFF -> after 32 cycles Result2=0xFFFFFFFE, Result1=0x00000001, Done pulse 1 cycle.
REQ-034 Op=00, -7 × 6 -> Result2=0xFFFFFFFF, Result1=0xFFFFFFD6; Busy high in Start cycle through cycle 31.
REQ-035 Op=10, -7 / 2 -> Result1=0xFFFFFFFD (-3), Result2=0xFFFFFFFF (-1); Op=11, 100 / 7 -> 14, 2.
REQ-036 Op=11, 0x1234 / 0 -> Result1=0xFFFFFFFF, Result2=0x1234; Op=10, 0x80000000 / 0xFFFFFFFF -> 0x80000000, 0.
REQ-037 Start mul, change operands and Op mid-run, pull RESETn low at cycle 10 -> immediate IDLE, results 0, no Done; restart 3×5 -> Result1=15.
REQ-038 Start held high across two ops -> second op begins the cycle after Done, correct results, Done pulses twice.
